mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the multicycle core's single unified instruction/data memory. It shares one single-port, 1-cycle-read-latency memory between the core's fetch/load/store port (CPU) and a debug/program-loader port (DBG). Each access is sequenced as a three-cycle IDLE→ISSUE→RESP transaction with a per-requester ack. The core FSM holds its current state until `cpu_ack`.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `ARB_MODE`, 0, arbitration policy: 0 = round-robin, 1 = DBG has fixed priority.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request, held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_adr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: read data, valid while `cpu_ack`=1, else 0.
- `cpu_ack` out 1: one-cycle completion pulse.
- `dbg_req`, `dbg_we`, `dbg_adr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same meanings, for the DBG requester.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_adr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: read data, valid the cycle after `mem_en`.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ISSUE: drives the memory.
  - RESP: returns data and ack.
- IDLE, with no request: stay in IDLE.
- IDLE, with ≥1 request: pick a winner, register its `we`/`adr`/`wdata` and the owner flag, then go to ISSUE.
- ISSUE:
  - `mem_en`=1.
  - `mem_we`, `mem_adr`, `mem_wdata` come from the registered values.
  - Always go to RESP.
- RESP:
  - Owner's ack=1.
  - Owner's rdata = `mem_rdata`; rdata is 0 for writes.
  - Always go to IDLE.
- Request inputs are sampled only in IDLE. Changing adr/data or dropping req after the grant does not affect the access, which completes and acks normally.
- Arbitration, both requesting in IDLE:
  - ARB_MODE=0: the requester not granted last wins. Register `last_gnt` is updated on every grant; reset value is DBG, so the CPU wins the first tie.
  - ARB_MODE=1: DBG always wins. CPU starvation is accepted, since debug halts the core.
- Single requester: that requester always wins, regardless of mode.
- Outputs not owned by the current state/owner are 0: `mem_*`, the non-owner's ack and rdata.

## Timing
- Request sampled at the edge ending cycle N (IDLE): ISSUE in N+1, RESP/ack in N+2, IDLE in N+3.
- Minimum 3 cycles per access. Peak throughput is one access per 3 cycles.
- The requester may present its next request from cycle N+3. A request held high through RESP is not re-granted for the same access; it is sampled fresh in IDLE.
- Worst-case CPU wait with ARB_MODE=0 and DBG continuously requesting: grant within 4 cycles of the request (one DBG access ahead of it).
- Reset:
  - `reset`=0 asynchronously forces IDLE, clears all outputs to 0, and sets `last_gnt`=DBG.
  - An access in ISSUE when reset asserts is abandoned. Completion of a write in flight is not guaranteed.
  - No ack is issued for an abandoned access; the requester reissues it.
- Reset deassertion: the first grant is possible in the IDLE cycle immediately following.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, ISSUE, RESP};
  - owner constants OWN_CPU=0, OWN_DBG=1;
  - ARB_MODE constants ARB_RR=0, ARB_DBG_PRIO=1.
- One combinational sub-module `arb_pick`:
  - inputs: `cpu_req`, `dbg_req`, `last_gnt`, `ARB_MODE`;
  - outputs: `gnt_valid`, `gnt_owner`.
- All sequential logic stays in `mem_arbiter`: state, owner, `last_gnt`, and the registered we/adr/wdata.

## Test plan
- Single CPU read: `cpu_req`=1, `cpu_adr`=0x100, `mem_rdata`=0xDEADBEEF in the cycle after `mem_en` → `mem_en` in cycle 1 with `mem_adr`=0x100, `cpu_ack`=1 and `cpu_rdata`=0xDEADBEEF in cycle 2, IDLE in cycle 3.
- DBG write: `dbg_we`=1, `dbg_adr`=0x20, `dbg_wdata`=0x12345678 → `mem_we`=1 and `mem_wdata`=0x12345678 in ISSUE, `dbg_ack` pulse in RESP, `dbg_rdata`=0, `cpu_ack`=0 throughout.
- Tie with ARB_MODE=0, both req held high for 4 accesses → grant order CPU, DBG, CPU, DBG; each ack is exactly 1 cycle and 3 cycles apart.
- Tie with ARB_MODE=1, both req held → DBG granted every time; `cpu_ack` never asserts until `dbg_req` drops, then the CPU is granted in the next IDLE.
- Late change: `cpu_adr` changed 0x100→0x200 during ISSUE → `mem_adr` stays 0x100.
- Reset mid-ISSUE: `reset`=0 asserted during ISSUE → `mem_en`, `mem_we` and both acks go 0 immediately. After release, state is IDLE and a held `cpu_req` is granted first with `cpu_ack` 2 cycles later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner and arbitration-mode definitions for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
  localparam int ARB_RR = 0;
  localparam int ARB_DBG_PRIO = 1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the CPU and DBG requesters
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_owner
);
  assign gnt_valid = cpu_req | dbg_req;
  // on a tie, round-robin hands the grant to whoever was not served last
  assign gnt_owner = !cpu_req ? OWN_DBG :
                     !dbg_req ? OWN_CPU :
                     (ARB_MODE == ARB_DBG_PRIO) ? OWN_DBG : ~last_gnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 1-cycle-latency memory between CPU and DBG via IDLE/ISSUE/RESP transactions
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_t        state;
  logic          owner, last_gnt, we_q, gnt_valid, gnt_owner;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .last_gnt (last_gnt),
    .gnt_valid(gnt_valid),
    .gnt_owner(gnt_owner)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= OWN_CPU;
      last_gnt <= OWN_DBG;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      mem_en   <= 1'b0;
      cpu_ack  <= 1'b0;
      dbg_ack  <= 1'b0;
    end else begin
      mem_en  <= state == IDLE && gnt_valid;
      cpu_ack <= state == ISSUE && owner == OWN_CPU;
      dbg_ack <= state == ISSUE && owner == OWN_DBG;
      case (state)
        IDLE: if (gnt_valid) begin
          state    <= ISSUE;
          owner    <= gnt_owner;
          last_gnt <= gnt_owner;
          we_q     <= gnt_owner == OWN_DBG ? dbg_we : cpu_we;
          adr_q    <= gnt_owner == OWN_DBG ? dbg_adr : cpu_adr;
          wdata_q  <= gnt_owner == OWN_DBG ? dbg_wdata : cpu_wdata;
        end
        ISSUE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  assign mem_we    = mem_en & we_q;
  assign mem_adr   = mem_en ? adr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign cpu_rdata = cpu_ack && !we_q ? mem_rdata : '0;
  assign dbg_rdata = dbg_ack && !we_q ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter in round-robin (g_dut[0]) and DBG-priority (g_dut[1]) modes
module tb_mem_arbiter;
  typedef struct packed {
    logic        k;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } mem_t;
  typedef struct packed {
    logic        k;
    logic        ca;
    logic        da;
    logic [31:0] cr;
    logic [31:0] dr;
  } ack_t;
  logic clk, reset;
  logic cpu_req[2], cpu_we[2], cpu_ack[2], dbg_req[2], dbg_we[2], dbg_ack[2];
  logic mem_en[2], mem_we[2];
  logic [31:0] cpu_adr[2], cpu_wdata[2], cpu_rdata[2], dbg_adr[2], dbg_wdata[2], dbg_rdata[2];
  logic [31:0] mem_adr[2], mem_wdata[2], mem_rdata[2];
  logic [31:0] ram[2][256];
  mem_t memq[$];
  ack_t ackq[$];
  int errors = 0, checks = 0, cyc = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.AW(32), .DW(32), .ARB_MODE(g)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_adr(cpu_adr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_adr(dbg_adr[g]), .dbg_wdata(dbg_wdata[g]),
      .dbg_rdata(dbg_rdata[g]), .dbg_ack(dbg_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  // memory model: one word per 4 bytes, read data appears the cycle after mem_en
  initial begin
    logic en[2], we[2];
    logic [31:0] adr[2], wd[2];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ram[k][i] = 32'h0;
      mem_rdata[k] = 32'hFFFF_FFFF;
    end
    ram[0][8'h40] = 32'hDEAD_BEEF;
    ram[0][8'h41] = 32'h1111_1111;
    ram[0][8'h09] = 32'h2222_2222;
    ram[1][8'h0C] = 32'h3333_3333;
    ram[1][8'h41] = 32'h4444_4444;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        en[k] = mem_en[k]; we[k] = mem_we[k]; adr[k] = mem_adr[k]; wd[k] = mem_wdata[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        mem_rdata[k] = !en[k] ? 32'hFFFF_FFFF : we[k] ? 32'hBAD0_BAD0 : ram[k][adr[k][9:2]];
        if (en[k] && we[k]) ram[k][adr[k][9:2]] = wd[k];
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mem_t m, mx;
      ack_t a, ax;
      checks++;
      if (mem_en[k]) begin
        mx = '{k[0], mem_we[k], mem_adr[k], mem_wdata[k]};
        if (memq.size() == 0) begin
          errors++;
          $display("FAIL mem_access dut%0d: unexpected access we=%0b adr=%h wdata=%h", k, mem_we[k], mem_adr[k], mem_wdata[k]);
        end else begin
          m = memq.pop_front();
          if (mx !== m) begin
            errors++;
            $display("FAIL mem_access dut%0d: got dut=%0d we=%0b adr=%h wdata=%h, expected dut=%0d we=%0b adr=%h wdata=%h",
                     k, mx.k, mx.we, mx.adr, mx.wdata, m.k, m.we, m.adr, m.wdata);
          end
        end
      end else if (mem_we[k] || mem_adr[k] != 0 || mem_wdata[k] != 0) begin
        errors++;
        $display("FAIL mem_idle dut%0d: got we=%0b adr=%h wdata=%h, expected all 0", k, mem_we[k], mem_adr[k], mem_wdata[k]);
      end
      checks++;
      ax = '{k[0], cpu_ack[k], dbg_ack[k], cpu_rdata[k], dbg_rdata[k]};
      if (cpu_ack[k] || dbg_ack[k]) begin
        if (ackq.size() == 0) begin
          errors++;
          $display("FAIL ack dut%0d: unexpected ack cpu=%0b dbg=%0b", k, cpu_ack[k], dbg_ack[k]);
        end else begin
          a = ackq.pop_front();
          if (ax !== a) begin
            errors++;
            $display("FAIL ack dut%0d: got dut=%0d cpu_ack=%0b dbg_ack=%0b cpu_rdata=%h dbg_rdata=%h, expected dut=%0d cpu_ack=%0b dbg_ack=%0b cpu_rdata=%h dbg_rdata=%h",
                     k, ax.k, ax.ca, ax.da, ax.cr, ax.dr, a.k, a.ca, a.da, a.cr, a.dr);
          end
        end
      end else if (cpu_rdata[k] != 0 || dbg_rdata[k] != 0) begin
        errors++;
        $display("FAIL rdata_idle dut%0d: got cpu_rdata=%h dbg_rdata=%h, expected 0", k, cpu_rdata[k], dbg_rdata[k]);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_acc(input int k, input logic own, input logic we, input logic [31:0] adr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
    memq.push_back('{k[0], we, adr, wdata});
    ackq.push_back('{k[0], !own, own, !own && !we ? rdata : 32'h0, own && !we ? rdata : 32'h0});
  endtask
  task automatic wait_ack(input int k, output int t);
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (cpu_ack[k] || dbg_ack[k]) t = cyc;
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL ack_timeout dut%0d: got no ack in 20 cycles, expected one", k);
    end
  endtask
  initial begin
    int t0, t, tp;
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 0; cpu_we[k] = 0; cpu_adr[k] = 0; cpu_wdata[k] = 0;
      dbg_req[k] = 0; dbg_we[k] = 0; dbg_adr[k] = 0; dbg_wdata[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctrl", {28'h0, mem_en[k], mem_we[k], cpu_ack[k], dbg_ack[k]}, 32'h0);
      chk("reset_rdata", cpu_rdata[k] | dbg_rdata[k] | mem_adr[k], 32'h0);
    end
    reset = 1;
    expect_acc(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    cpu_we[0] = 0; cpu_adr[0] = 32'h100; cpu_req[0] = 1; t0 = cyc;
    wait_ack(0, t);
    cpu_req[0] = 0;
    chk("cpu_read_latency", t - t0, 2);
    @(negedge clk);
    chk("idle_after_resp", {29'h0, mem_en[0], cpu_ack[0], dbg_ack[0]}, 32'h0);
    expect_acc(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
    dbg_we[0] = 1; dbg_adr[0] = 32'h20; dbg_wdata[0] = 32'h1234_5678; dbg_req[0] = 1; t0 = cyc;
    wait_ack(0, t);
    dbg_req[0] = 0;
    chk("dbg_write_latency", t - t0, 2);
    @(negedge clk);
    expect_acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
    dbg_we[0] = 0; dbg_wdata[0] = 0; dbg_req[0] = 1;
    wait_ack(0, t);
    dbg_req[0] = 0;
    @(negedge clk);
    // round-robin tie: DBG was served last, so CPU goes first
    expect_acc(0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h1111_1111);
    expect_acc(0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h2222_2222);
    expect_acc(0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h1111_1111);
    expect_acc(0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h2222_2222);
    cpu_adr[0] = 32'h104; dbg_adr[0] = 32'h24; cpu_req[0] = 1; dbg_req[0] = 1; tp = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, t);
      chk(i == 0 ? "rr_first_latency" : "rr_ack_spacing", t - tp, i == 0 ? 2 : 3);
      tp = t;
    end
    cpu_req[0] = 0; dbg_req[0] = 0;
    @(negedge clk);
    expect_acc(1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h3333_3333);
    expect_acc(1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h3333_3333);
    expect_acc(1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h3333_3333);
    expect_acc(1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h4444_4444);
    cpu_adr[1] = 32'h104; dbg_adr[1] = 32'h30; cpu_req[1] = 1; dbg_req[1] = 1; tp = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1, t);
      chk(i == 0 ? "prio_first_latency" : "prio_ack_spacing", t - tp, i == 0 ? 2 : 3);
      tp = t;
      if (i == 2) dbg_req[1] = 0;
    end
    cpu_req[1] = 0;
    @(negedge clk);
    expect_acc(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    cpu_adr[0] = 32'h100; cpu_req[0] = 1; t0 = cyc;
    @(negedge clk);
    cpu_adr[0] = 32'h200; cpu_req[0] = 0;
    wait_ack(0, t);
    chk("late_change_latency", t - t0, 2);
    @(negedge clk);
    memq.push_back('{1'b0, 1'b1, 32'h200, 32'hCAFE_F00D});
    cpu_we[0] = 1; cpu_adr[0] = 32'h200; cpu_wdata[0] = 32'hCAFE_F00D; cpu_req[0] = 1;
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("reset_issue_ctrl", {28'h0, mem_en[0], mem_we[0], cpu_ack[0], dbg_ack[0]}, 32'h0);
    chk("reset_issue_adr", mem_adr[0], 32'h0);
    cpu_we[0] = 0; cpu_adr[0] = 32'h100; cpu_wdata[0] = 0;
    @(negedge clk);
    chk("reset_held_ctrl", {30'h0, mem_en[0], cpu_ack[0]}, 32'h0);
    expect_acc(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    reset = 1; t0 = cyc;
    wait_ack(0, t);
    cpu_req[0] = 0;
    chk("post_reset_latency", t - t0, 2);
    repeat (3) @(negedge clk);
    chk("memq_drained", memq.size(), 0);
    chk("ackq_drained", ackq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
